// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order memory reads under a credit limit,
// and buffers returned instructions with their PC+PC_INC for decode.
module instruction_fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] target_bp,
    input  logic              target_en_bp,
    output logic [ADDR_W-1:0] next_program_counter_if_to_bp,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] address_to_memory,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] data_from_memory,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instruction_if,
    output logic [ADDR_W-1:0] next_program_counter_if
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int TAG_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    localparam logic [ADDR_W-1:0] INC_C      = ADDR_W'(PC_INC);
    localparam logic [OUT_W-1:0]  MAX_OUT_C  = OUT_W'(MAX_OUT);
    localparam logic [SUM_W-1:0]  DEPTH_C    = SUM_W'(DEPTH);
    localparam logic [TAG_W-1:0]  TAG_LAST_C = TAG_W'(MAX_OUT - 1);

    // Tag FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] ptr);
        return (ptr == TAG_LAST_C) ? {TAG_W{1'b0}} : ptr + TAG_W'(1);
    endfunction

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [CNT_W-1:0]  count_r;
    logic [OUT_W-1:0]  outstanding_r;
    logic [OUT_W-1:0]  drop_cnt_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [TAG_W-1:0]  tag_rd_r;
    logic [TAG_W-1:0]  tag_wr_r;
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [ADDR_W-1:0] tag_mem_r  [MAX_OUT];

    logic [SUM_W-1:0]  occupancy_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;

    // Credit check, handshakes and head-of-queue presentation.
    always_comb begin
        occupancy_s   = SUM_W'(count_r) + SUM_W'(outstanding_r);
        mem_req_valid = !reset && !target_en_bp && (outstanding_r < MAX_OUT_C)
                        && (occupancy_s < DEPTH_C);
        issue_s       = mem_req_valid && mem_req_ready;
        instr_valid   = !reset && (count_r != {CNT_W{1'b0}});
        pop_s         = instr_valid && instr_ready && !target_en_bp;
        push_s        = mem_rsp_valid && (drop_cnt_r == {OUT_W{1'b0}}) && !target_en_bp;
        address_to_memory             = fetch_pc_r;
        next_program_counter_if_to_bp = fetch_pc_r + INC_C;
        if (instr_valid) begin
            instruction_if          = data_mem_r[rd_ptr_r];
            next_program_counter_if = pc_mem_r[rd_ptr_r];
        end else begin
            instruction_if          = {DATA_W{1'b0}};
            next_program_counter_if = {ADDR_W{1'b0}};
        end
    end

    // Control state: fetch PC, credit counters, drop counter and queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            count_r       <= {CNT_W{1'b0}};
            outstanding_r <= {OUT_W{1'b0}};
            drop_cnt_r    <= {OUT_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            tag_rd_r      <= {TAG_W{1'b0}};
            tag_wr_r      <= {TAG_W{1'b0}};
        end else begin
            if (target_en_bp) begin
                fetch_pc_r <= target_bp;
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + INC_C;
            end
            outstanding_r <= outstanding_r + OUT_W'(issue_s) - OUT_W'(mem_rsp_valid);
            // Everything still in flight after a redirect belongs to the old path.
            if (target_en_bp) begin
                drop_cnt_r <= outstanding_r - OUT_W'(mem_rsp_valid);
            end else if (mem_rsp_valid && (drop_cnt_r != {OUT_W{1'b0}})) begin
                drop_cnt_r <= drop_cnt_r - OUT_W'(1);
            end
            if (issue_s) begin
                tag_wr_r <= tag_next(tag_wr_r);
            end
            if (mem_rsp_valid) begin
                tag_rd_r <= tag_next(tag_rd_r);
            end
            if (target_en_bp) begin
                count_r  <= {CNT_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
        end
    end

    // Storage arrays; contents are only meaningful where the pointers say so.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            tag_mem_r[tag_wr_r] <= fetch_pc_r + INC_C;
        end
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= data_from_memory;
            pc_mem_r[wr_ptr_r]   <= tag_mem_r[tag_rd_r];
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized bench for instruction_fetch_queue: the bench plays instruction memory and
// compares the DUT each cycle against a queue-based model of the fetch stage.
module tb_instruction_fetch_queue;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] target_bp;
    logic              target_en_bp;
    logic [ADDR_W-1:0] next_program_counter_if_to_bp;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] address_to_memory;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] data_from_memory;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instruction_if;
    logic [ADDR_W-1:0] next_program_counter_if;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT),
        .RESET_PC(16'h0000), .PC_INC(1)
    ) dut (
        .clk(clk), .reset(reset),
        .target_bp(target_bp), .target_en_bp(target_en_bp),
        .next_program_counter_if_to_bp(next_program_counter_if_to_bp),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .address_to_memory(address_to_memory),
        .mem_rsp_valid(mem_rsp_valid), .data_from_memory(data_from_memory),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction_if(instruction_if),
        .next_program_counter_if(next_program_counter_if)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] tag;
        bit                stale;
        int                due;
    } req_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    req_t              inflight[$];
    ent_t              fifo_q[$];
    logic [ADDR_W-1:0] m_pc;
    int                last_due;
    int                cyc;
    int                tests_run;
    int                tests_failed;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic model_clear();
        inflight.delete();
        fifo_q.delete();
        m_pc     = 16'h0000;
        last_due = 0;
    endtask

    task automatic drive_idle();
        target_bp        = 16'h0000;
        target_en_bp     = 1'b0;
        mem_req_ready    = 1'b0;
        mem_rsp_valid    = 1'b0;
        data_from_memory = 16'h0000;
        instr_ready      = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        check_val("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_val("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_val("rst_instr", 32'(instruction_if), 32'd0);
        check_val("rst_next_pc", 32'(next_program_counter_if), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        check_val("rst_addr", 32'(address_to_memory), 32'h0000);
        check_val("rst_req_valid_after", 32'(mem_req_valid), 32'd1);
    endtask

    task automatic run_cycles(input int n, input int p_mem, input int p_dec,
                              input int p_redir, input int max_lat);
        for (int i = 0; i < n; i++) begin
            bit   exp_req;
            bit   issue;
            bit   pop;
            req_t r;
            int   due;
            @(posedge clk); #1;
            cyc++;
            mem_req_ready = ($urandom_range(99) < p_mem);
            instr_ready   = ($urandom_range(99) < p_dec);
            target_en_bp  = ($urandom_range(99) < p_redir);
            case ($urandom_range(3))
                0:       target_bp = 16'h0100;
                1:       target_bp = 16'hFFFE;
                2:       target_bp = 16'hFFFF;
                default: target_bp = 16'($urandom);
            endcase
            mem_rsp_valid = (inflight.size() > 0) && (inflight[0].due <= cyc);
            data_from_memory = mem_rsp_valid ? mem_data(inflight[0].addr) : 16'($urandom);

            @(negedge clk);
            exp_req = !target_en_bp && (inflight.size() < MAX_OUT)
                      && (fifo_q.size() + inflight.size() < DEPTH);
            check_val("req_valid", 32'(mem_req_valid), 32'(exp_req));
            check_val("address", 32'(address_to_memory), 32'(m_pc));
            check_val("bp_next_pc", 32'(next_program_counter_if_to_bp), 32'(16'(m_pc + 16'd1)));
            check_val("instr_valid", 32'(instr_valid), 32'(fifo_q.size() != 0));
            if (fifo_q.size() != 0) begin
                check_val("instr", 32'(instruction_if), 32'(fifo_q[0].data));
                check_val("next_pc", 32'(next_program_counter_if), 32'(fifo_q[0].pc));
            end else begin
                check_val("instr_empty", 32'(instruction_if), 32'd0);
                check_val("next_pc_empty", 32'(next_program_counter_if), 32'd0);
            end

            issue = exp_req && mem_req_ready;
            pop   = (fifo_q.size() != 0) && instr_ready && !target_en_bp;
            if (pop) begin
                void'(fifo_q.pop_front());
            end
            if (mem_rsp_valid) begin
                r = inflight.pop_front();
                if (!target_en_bp && !r.stale) begin
                    fifo_q.push_back('{data: data_from_memory, pc: r.tag});
                end
            end
            if (target_en_bp) begin
                fifo_q.delete();
                foreach (inflight[j]) inflight[j].stale = 1'b1;
                m_pc = target_bp;
            end
            if (issue) begin
                due = cyc + int'($urandom_range(max_lat, 1));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                inflight.push_back('{addr: m_pc, tag: 16'(m_pc + 16'd1), stale: 1'b0, due: due});
                m_pc = m_pc + 16'd1;
            end
            if (fifo_q.size() > DEPTH) begin
                check_val("model_fifo_bound", 32'(fifo_q.size()), 32'(DEPTH));
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset        = 1'b1;
        drive_idle();
        model_clear();
        do_reset();
        // Streaming at unit latency, then back-pressure from decode and release.
        run_cycles(30, 100, 100, 0, 1);
        run_cycles(20, 100, 0, 0, 1);
        run_cycles(20, 100, 100, 0, 1);
        // Longer memory latency limited by the outstanding-request credit.
        run_cycles(60, 100, 100, 0, 3);
        // Redirect-heavy traffic, including redirects with a full queue.
        run_cycles(500, 70, 60, 5, 3);
        run_cycles(500, 90, 20, 8, 2);
        do_reset();
        run_cycles(600, 80, 50, 4, 4);
        do_reset();
        run_cycles(300, 100, 100, 3, 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
